// File: rtl/kuuga_bram_pkg.sv
// Shared types and helpers for the BRAM initiator slice.
package kuuga_bram_pkg;

    localparam int RESP_DW = 32;

    typedef struct packed {
        logic valid;
        logic is_write;
    } lat_t;

    typedef struct packed {
        logic               is_write;
        logic [RESP_DW-1:0] data;
    } resp_t;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

    // Clears the byte-lane bits of a byte address.
    function automatic logic [63:0] align_mask(input int dw);
        return ~64'(be_width(dw) - 1);
    endfunction

endpackage

// File: rtl/kuuga_bram_initiator_if.sv
// Core-side req/gnt/rvalid bus between a core and the BRAM initiator.
interface kuuga_bram_initiator_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();
    import kuuga_bram_pkg::*;

    localparam int BW = be_width(DATA_WIDTH);

    logic                  req_i;
    logic                  gnt_o;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [BW-1:0]         be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/kuuga_resp_fifo.sv
// Response FIFO; pointers carry a wrap bit to tell full from empty.
module kuuga_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Credits bound occupancy, so a push into a full FIFO is a design bug.
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/kuuga_bram_initiator.sv
// Core-side initiator driving one fixed-latency byte-addressed BRAM port.
module kuuga_bram_initiator
    import kuuga_bram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    kuuga_bram_initiator_if.slave   core,
    output logic                    bram_clk_o,
    output logic                    bram_rst_o,
    output logic [ADDR_WIDTH-1:0]   bram_addr_o,
    output logic                    bram_en_o,
    output logic [DATA_WIDTH/8-1:0] bram_we_o,
    output logic [DATA_WIDTH-1:0]   bram_wrdata_o,
    input  logic [DATA_WIDTH-1:0]   bram_rddata_i
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN =
        ADDR_WIDTH'(align_mask(DATA_WIDTH));

    logic [CW-1:0]         outstanding;
    logic                  gnt;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] head;
    lat_t                  pipe [READ_LATENCY];

    assign gnt = core.req_i && !reset &&
                 (outstanding < CW'(MAX_OUTSTANDING));
    assign pop = core.rvalid_o && core.rready_i;

    assign core.gnt_o    = gnt;
    assign core.rvalid_o = !empty;
    assign core.rdata_o  = empty ? '0 : head;

    assign bram_clk_o    = clk;
    assign bram_rst_o    = reset;
    assign bram_en_o     = gnt;
    assign bram_we_o     = (gnt && core.we_i) ? core.be_i : '0;
    assign bram_addr_o   = core.addr_i & ALIGN;
    assign bram_wrdata_o = core.wdata_i;

    always_ff @(posedge clk) begin
        if (reset)
            outstanding <= '0;
        else if (gnt && !pop)
            outstanding <= outstanding + 1'b1;
        else if (!gnt && pop)
            outstanding <= outstanding - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: gnt, is_write: core.we_i};
            for (int i = 1; i < READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    // Write responses carry zero data rather than whatever the BRAM drives.
    assign push      = pipe[READ_LATENCY-1].valid;
    assign push_data = pipe[READ_LATENCY-1].is_write ? '0 : bram_rddata_i;

    kuuga_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_kuuga_bram_initiator.sv
// Directed bench for kuuga_bram_initiator with a 2-cycle BRAM model.
module tb_kuuga_bram_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        bram_clk;
    logic        bram_rst;
    logic [15:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    kuuga_bram_initiator_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    kuuga_bram_initiator dut (
        .clk           (clk),
        .reset         (reset),
        .core          (bus),
        .bram_clk_o    (bram_clk),
        .bram_rst_o    (bram_rst),
        .bram_addr_o   (bram_addr),
        .bram_en_o     (bram_en),
        .bram_we_o     (bram_we),
        .bram_wrdata_o (bram_wrdata),
        .bram_rddata_i (bram_rddata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            8:       return 32'h12345678;
            default: return 32'hA5000000 | (i << 8) | i;
        endcase
    endfunction

    // BRAM model: read-first, data visible two cycles after enable.
    logic [31:0] mem [64];
    logic [31:0] q1;
    logic [31:0] q2;
    logic        loaded = 1'b0;

    assign bram_rddata = q2;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else begin
            q2 <= q1;
            if (bram_en) begin
                q1 <= mem[bram_addr[7:2]];
                for (int b = 0; b < 4; b++)
                    if (bram_we[b])
                        mem[bram_addr[7:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
            end
        end
    end

    logic        collect = 1'b0;
    logic [31:0] sq [$];

    always @(negedge clk)
        if (collect && bus.rvalid_o && bus.rready_i)
            sq.push_back(bus.rdata_o);

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(input string tag,
                             output logic [31:0] d,
                             output int c);
        bit found = 1'b0;
        d = '0;
        c = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.rvalid_o) begin
                d = bus.rdata_o;
                c = cyc;
                found = 1'b1;
            end
        end
        if (!found)
            check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d;
    int          c;
    int          t0;
    int          ng;
    int          nv;

    initial begin
        reset        = 1'b1;
        bus.req_i    = 1'b1;
        bus.addr_i   = '0;
        bus.we_i     = 1'b0;
        bus.be_i     = '0;
        bus.wdata_i  = '0;
        bus.rready_i = 1'b1;

        next;
        next;
        @(negedge clk);
        check("rst_gnt", bus.gnt_o, 0);
        check("rst_rvalid", bus.rvalid_o, 0);
        check("rst_rdata", bus.rdata_o, 0);
        check("rst_en", bram_en, 0);
        check("rst_we", bram_we, 0);

        next;
        reset     = 1'b0;
        bus.req_i = 1'b0;
        next;

        // single read with unaligned address
        bus.req_i  = 1'b1;
        bus.addr_i = 16'h0013;
        @(negedge clk);
        check("rd_gnt", bus.gnt_o, 1);
        check("rd_addr", bram_addr, 16'h0010);
        check("rd_en", bram_en, 1);
        t0 = cyc;
        next;
        bus.req_i = 1'b0;
        @(negedge clk);
        check("rd_en_1cyc", bram_en, 0);
        wait_resp("rd", d, c);
        check("rd_lat", c - t0, 3);
        check("rd_data", d, 32'hDEADBEEF);

        // partial write then read back
        next;
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 16'h0020;
        bus.be_i    = 4'b0011;
        bus.wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        check("wr_we", bram_we, 4'b0011);
        check("wr_wdata", bram_wrdata, 32'hCAFEF00D);
        next;
        bus.req_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.be_i  = '0;
        @(negedge clk);
        check("wr_we_1cyc", bram_we, 0);
        wait_resp("wr", d, c);
        check("wr_resp", d, 0);
        next;
        bus.req_i  = 1'b1;
        bus.addr_i = 16'h0020;
        next;
        bus.req_i = 1'b0;
        wait_resp("rb", d, c);
        check("rb_data", d, 32'h1234F00D);

        // backpressure: credits cap grants at four
        next;
        bus.rready_i = 1'b0;
        ng = 0;
        for (int k = 0; k < 6; k++) begin
            bus.req_i  = 1'b1;
            bus.addr_i = 16'(ng * 4);
            @(negedge clk);
            if (bus.gnt_o) ng++;
            next;
        end
        check("bp_grants", ng, 4);
        bus.addr_i = 16'(ng * 4);
        @(negedge clk);
        check("bp_gnt_low", bus.gnt_o, 0);
        next;
        bus.rready_i = 1'b1;
        @(negedge clk);
        check("pop_no_bypass", bus.gnt_o, 0);
        check("pop_rvalid", bus.rvalid_o, 1);
        check("pop_data0", bus.rdata_o, init_word(0));
        next;
        bus.rready_i = 1'b0;
        @(negedge clk);
        check("grant_after_pop", bus.gnt_o, 1);
        next;
        @(negedge clk);
        check("credits_full_again", bus.gnt_o, 0);
        next;
        bus.req_i    = 1'b0;
        bus.rready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            wait_resp("bp_drain", d, c);
            check("bp_data", d, init_word(k));
        end
        @(negedge clk);
        check("bp_empty", bus.rvalid_o, 0);

        // reset with three reads in flight
        next;
        for (int k = 0; k < 3; k++) begin
            bus.req_i  = 1'b1;
            bus.addr_i = 16'(k * 4);
            next;
        end
        reset = 1'b1;
        next;
        @(negedge clk);
        check("mid_rst_gnt", bus.gnt_o, 0);
        check("mid_rst_rvalid", bus.rvalid_o, 0);
        next;
        reset     = 1'b0;
        bus.req_i = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.rvalid_o) nv++;
            next;
        end
        check("no_rvalid_after_rst", nv, 0);
        bus.req_i  = 1'b1;
        bus.addr_i = 16'h0013;
        @(negedge clk);
        t0 = cyc;
        next;
        bus.req_i = 1'b0;
        wait_resp("post_rst", d, c);
        check("post_rst_lat", c - t0, 3);
        check("post_rst_data", d, 32'hDEADBEEF);

        // streaming reads at full rate
        next;
        collect = 1'b1;
        ng = 0;
        for (int k = 0; k < 16; k++) begin
            bus.req_i  = 1'b1;
            bus.addr_i = 16'(ng * 4);
            @(negedge clk);
            if (bus.gnt_o) ng++;
            next;
        end
        bus.req_i = 1'b0;
        check("stream_grants", ng, 16);
        for (int k = 0; k < 30 && sq.size() < 16; k++)
            @(negedge clk);
        check("stream_count", sq.size(), 16);
        for (int k = 0; k < 16; k++)
            check("stream_data", sq[k],
                  (k == 8) ? 32'h1234F00D : init_word(k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
